// File: rtl/aha_tlx_mon_pkg.sv
// aha_tlx_mon_pkg: shared state encoding, default training word and error counter width
package aha_tlx_mon_pkg;
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_PASS    = 2'd3
  } mon_state_e;
  localparam logic [31:0] DEFAULT_PATTERN = 32'hF0F0_A5C3;
  localparam int ERR_W = 16;
endpackage

// File: rtl/aha_tlx_pattern_detector.sv
// aha_tlx_pattern_detector: serial shift register, word bit counter and training word compare
// Mismatch messages are printed only when AHA_TLX_MON_DISPLAY_EN is defined.
module aha_tlx_pattern_detector import aha_tlx_mon_pkg::*; #(
  parameter int PATTERN_W = 32,
  parameter logic [PATTERN_W-1:0] PATTERN = PATTERN_W'(DEFAULT_PATTERN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic clr,
  input  logic track,
  output logic match,
  output logic boundary
);
  localparam int CW = PATTERN_W > 1 ? $clog2(PATTERN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(PATTERN_W - 1);
  logic [PATTERN_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter only runs while tracking an aligned stream; it sits at 0 in search so alignment restarts it.
  always_comb begin
    sr_d = clr ? '0 : en ? {sr_q[PATTERN_W-2:0], din} : sr_q;
    cnt_d = clr ? '0 : !en ? cnt_q : !track ? '0 : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    match = sr_d == PATTERN;
    boundary = en && !clr && track && cnt_q == LAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef AHA_TLX_MON_DISPLAY_EN
  always @(posedge clk) begin
    if (rst_n && boundary && !match)
      $display("%0t aha_tlx_mon: word error expected %h received %h", $time, PATTERN, sr_d);
  end
`endif
endmodule

// File: rtl/aha_tlx_training_monitor.sv
// aha_tlx_training_monitor: lane-0 training lock monitor with echo delay and pass-through
// Define AHA_TLX_MON_DISPLAY_EN for simulation messages on lock, word errors and OE changes.
module aha_tlx_training_monitor import aha_tlx_mon_pkg::*; #(
  parameter int PATTERN_W = 32,
  parameter logic [PATTERN_W-1:0] PATTERN = PATTERN_W'(DEFAULT_PATTERN),
  parameter int LOCK_COUNT = 4,
  parameter int LOOP_DELAY = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             OE,
  input  logic             FWD_DATA_IN,
  input  logic             REV_DATA_IN,
  output logic             REV_DATA_OUT,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [1:0]       STATE
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  mon_state_e state_q, state_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic locked_q, locked_d;
  logic [LOOP_DELAY-1:0] dly_q, dly_d;
  logic match, boundary, clr, track;
  // Being in PASS while OE is low marks the OE falling edge.
  assign clr = !OE && state_q == ST_PASS;
  assign track = state_q == ST_ALIGNED || state_q == ST_LOCKED;
  aha_tlx_pattern_detector #(
    .PATTERN_W(PATTERN_W),
    .PATTERN  (PATTERN)
  ) u_det (
    .clk     (CLK),
    .rst_n   (RESETn),
    .en      (!OE),
    .din     (FWD_DATA_IN),
    .clr     (clr),
    .track   (track),
    .match   (match),
    .boundary(boundary)
  );
  always_comb begin
    state_d = state_q;
    mcnt_d = mcnt_q;
    err_d = err_q;
    dly_d = LOOP_DELAY'({dly_q, FWD_DATA_IN});
    if (OE) begin
      state_d = ST_PASS;
    end else if (clr) begin
      state_d = ST_SEARCH;
      mcnt_d = '0;
    end else if (state_q == ST_SEARCH && match) begin
      mcnt_d = MW'(1);
      state_d = LOCK_COUNT <= 1 ? ST_LOCKED : ST_ALIGNED;
    end else if (boundary && match) begin
      mcnt_d = (mcnt_q == MW'(LOCK_COUNT)) ? mcnt_q : mcnt_q + 1'b1;
      state_d = (mcnt_d == MW'(LOCK_COUNT)) ? ST_LOCKED : state_q;
    end else if (boundary) begin
      mcnt_d = '0;
      state_d = ST_SEARCH;
      err_d = &err_q ? err_q : err_q + 1'b1;
    end
    locked_d = state_d == ST_LOCKED;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_SEARCH;
      mcnt_q <= '0;
      err_q <= '0;
      locked_q <= 1'b0;
      dly_q <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q <= mcnt_d;
      err_q <= err_d;
      locked_q <= locked_d;
      dly_q <= dly_d;
    end
  end
  assign REV_DATA_OUT = OE ? REV_DATA_IN : dly_q[LOOP_DELAY-1];
  assign LOCKED = locked_q;
  assign ERR_COUNT = err_q;
  assign STATE = state_q;
`ifdef AHA_TLX_MON_DISPLAY_EN
  always @(posedge CLK) begin
    if (RESETn && locked_d && !locked_q)
      $display("%0t aha_tlx_mon: LOCKED rise", $time);
    if (RESETn && OE != (state_q == ST_PASS))
      $display("%0t aha_tlx_mon: OE changed to %0b", $time, OE);
  end
`endif
endmodule

// File: tb/tb_aha_tlx_training_monitor.sv
// tb_aha_tlx_training_monitor: directed vector table plus hand-written lock, error and reset sequences
module tb_aha_tlx_training_monitor;
  localparam logic [31:0] P = 32'hF0F0_A5C3;
  logic CLK, RESETn, OE, FWD_DATA_IN, REV_DATA_IN;
  logic REV_DATA_OUT, LOCKED;
  logic [15:0] ERR_COUNT;
  logic [1:0] STATE;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic oe;
    logic fwd;
    logic rev;
    logic exp_out;
    logic [1:0] exp_st;
  } vec_t;
  vec_t tbl [13];

  aha_tlx_training_monitor dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .OE          (OE),
    .FWD_DATA_IN (FWD_DATA_IN),
    .REV_DATA_IN (REV_DATA_IN),
    .REV_DATA_OUT(REV_DATA_OUT),
    .LOCKED      (LOCKED),
    .ERR_COUNT   (ERR_COUNT),
    .STATE       (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_range(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      FWD_DATA_IN = w[i];
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_range(w, 31, 0);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    FWD_DATA_IN = 1'b0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd3};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    RESETn = 1'b0;
    OE = 1'b0;
    FWD_DATA_IN = 1'b0;
    REV_DATA_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(STATE), 0);
    chk("rst_locked", 32'(LOCKED), 0);
    chk("rst_err", 32'(ERR_COUNT), 0);
    chk("rst_out_oe0", 32'(REV_DATA_OUT), 0);
    OE = 1'b1;
    REV_DATA_IN = 1'b1;
    #1;
    chk("rst_out_oe1", 32'(REV_DATA_OUT), 1);
    OE = 1'b0;
    REV_DATA_IN = 1'b0;
    #1;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    // echo delay and pass-through table
    for (int i = 0; i < 13; i++) begin
      OE = tbl[i].oe;
      FWD_DATA_IN = tbl[i].fwd;
      REV_DATA_IN = tbl[i].rev;
      #1;
      chk($sformatf("vec%0d_out", i), 32'(REV_DATA_OUT), 32'(tbl[i].exp_out));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(STATE), 32'(tbl[i].exp_st));
    end
    chk("vec_err", 32'(ERR_COUNT), 0);
    // lock after four clean words
    do_reset();
    send_word(P);
    chk("w1_state", 32'(STATE), 1);
    send_word(P);
    send_word(P);
    chk("w3_state", 32'(STATE), 1);
    chk("w3_locked", 32'(LOCKED), 0);
    send_range(P, 31, 1);
    chk("w4_pre_locked", 32'(LOCKED), 0);
    send_range(P, 0, 0);
    chk("w4_locked", 32'(LOCKED), 1);
    chk("w4_state", 32'(STATE), 2);
    chk("w4_err", 32'(ERR_COUNT), 0);
    // bit error in the sixth word, then relock
    send_word(P);
    chk("w5_state", 32'(STATE), 2);
    send_word(P ^ 32'h0001_0000);
    chk("w6_err", 32'(ERR_COUNT), 1);
    chk("w6_state", 32'(STATE), 0);
    chk("w6_locked", 32'(LOCKED), 0);
    send_word(P);
    chk("re1_state", 32'(STATE), 1);
    send_word(P);
    send_word(P);
    chk("re3_locked", 32'(LOCKED), 0);
    send_word(P);
    chk("re4_locked", 32'(LOCKED), 1);
    chk("re4_err", 32'(ERR_COUNT), 1);
    // pass-through while locked
    OE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      REV_DATA_IN = k[0];
      #1;
      chk($sformatf("pass%0d_out", k), 32'(REV_DATA_OUT), 32'(k[0]));
      @(posedge CLK);
      #1;
      chk($sformatf("pass%0d_state", k), 32'(STATE), 3);
      chk($sformatf("pass%0d_locked", k), 32'(LOCKED), 0);
    end
    chk("pass_err", 32'(ERR_COUNT), 1);
    OE = 1'b0;
    FWD_DATA_IN = 1'b0;
    @(posedge CLK);
    #1;
    chk("oefall_state", 32'(STATE), 0);
    // OE rise on a failing word boundary wins
    send_word(P);
    chk("ob_align", 32'(STATE), 1);
    send_range(32'h0, 31, 1);
    OE = 1'b1;
    FWD_DATA_IN = 1'b0;
    @(posedge CLK);
    #1;
    chk("ob_state", 32'(STATE), 3);
    chk("ob_err", 32'(ERR_COUNT), 1);
    OE = 1'b0;
    @(posedge CLK);
    #1;
    chk("ob_search", 32'(STATE), 0);
    // asynchronous reset mid-word while locked
    repeat (4) send_word(P);
    chk("ar_locked", 32'(LOCKED), 1);
    send_range(P, 31, 22);
    #2;
    RESETn = 1'b0;
    #1;
    chk("ar_rst_locked", 32'(LOCKED), 0);
    chk("ar_rst_state", 32'(STATE), 0);
    chk("ar_rst_err", 32'(ERR_COUNT), 0);
    chk("ar_rst_out", 32'(REV_DATA_OUT), 0);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    send_word(P);
    chk("ar1_state", 32'(STATE), 1);
    send_word(P);
    send_word(P);
    chk("ar3_locked", 32'(LOCKED), 0);
    send_word(P);
    chk("ar4_locked", 32'(LOCKED), 1);
    // error counter: 500 errors, then saturation
    do_reset();
    for (int n = 0; n < 500; n++) begin
      send_word(P);
      send_word(32'h0);
      if (n == 0) chk("err_first", 32'(ERR_COUNT), 1);
    end
    chk("err_500", 32'(ERR_COUNT), 500);
    force dut.err_q = 16'hFFFF;
    send_word(P);
    send_word(32'h0);
    release dut.err_q;
    send_word(P);
    send_word(32'h0);
    chk("err_sat", 32'(ERR_COUNT), 32'h0000_FFFF);
    chk("err_sat_state", 32'(STATE), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
